// File: rtl/kcounter_ctrl_pkg.sv
// Shared types for the DPLL K-counter loop filter and its correction scheduler.
package kcounter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GUARD = 2'd2
  } issue_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/kcounter_core.sv
// Modulo-K up/down counter that emits a carry at the top and a borrow at zero,
// reloading to mid-scale on either event or on a synchronous flush.
module kcounter_core #(
  parameter int K_MOD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic dn_up,
  input  logic clr,
  output logic carry,
  output logic borrow
);

  localparam int KW = $clog2(K_MOD);
  localparam logic [KW-1:0] KHALF = KW'(K_MOD / 2);
  localparam logic [KW-1:0] KTOP  = KW'(K_MOD - 1);

  logic [KW-1:0] kcnt_q, kcnt_d;

  always_comb begin
    carry  = enable && !dn_up && (kcnt_q == KTOP);
    borrow = enable && dn_up && (kcnt_q == '0);
    kcnt_d = kcnt_q;
    if (clr || carry || borrow) begin
      kcnt_d = KHALF;
    end else if (enable) begin
      kcnt_d = dn_up ? kcnt_q - 1'b1 : kcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) kcnt_q <= KHALF;
    else       kcnt_q <= kcnt_d;
  end

endmodule

// File: rtl/kcounter_ctrl.sv
// DPLL loop filter: K-counter events feed a saturating signed pending count that is
// drained as single, guard-spaced inc/dec pulses toward the ID counter.
module kcounter_ctrl
  import kcounter_ctrl_pkg::*;
#(
  parameter int K_MOD     = 8,
  parameter int PEND_W    = 4,
  parameter int PULSE_LEN = 1,
  parameter int GUARD     = 2,
  parameter int LOCK_CYC  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     dn_up,
  input  logic                     clr,
  output logic                     inc,
  output logic                     dec,
  output logic signed [PEND_W-1:0] pending,
  output logic                     sat,
  output logic                     locked
);

  localparam int TMR_W  = $clog2(max2(PULSE_LEN, GUARD) + 1);
  localparam int LOCK_W = $clog2(LOCK_CYC + 1);
  localparam int SUM_W  = PEND_W + 2;
  localparam logic signed [SUM_W-1:0] PEND_MAX   = SUM_W'((1 << (PEND_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] PEND_MIN   = -PEND_MAX;
  localparam logic [TMR_W-1:0]        PULSE_LAST = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0]        GUARD_LAST = TMR_W'(GUARD - 1);
  localparam logic [LOCK_W-1:0]       LOCK_TOP   = LOCK_W'(LOCK_CYC);

  function automatic logic signed [PEND_W-1:0] clamp_pend(input logic signed [SUM_W-1:0] v);
    if (v > PEND_MAX) return PEND_MAX[PEND_W-1:0];
    if (v < PEND_MIN) return PEND_MIN[PEND_W-1:0];
    return v[PEND_W-1:0];
  endfunction

  logic carry_raw, borrow_raw, evt_carry, evt_borrow;
  logic pend_pos, pend_neg, iss_inc, iss_dec;
  logic [1:0] add, sub;
  logic signed [SUM_W-1:0] sum;

  issue_state_e               state_q, state_d;
  logic [TMR_W-1:0]           tmr_q, tmr_d;
  logic                       inc_q, inc_d, dec_q, dec_d, sat_q, sat_d;
  logic signed [PEND_W-1:0]   pending_q, pending_d;
  logic [LOCK_W-1:0]          lock_cnt_q, lock_cnt_d;

  kcounter_core #(.K_MOD(K_MOD)) u_core (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .dn_up  (dn_up),
    .clr    (clr),
    .carry  (carry_raw),
    .borrow (borrow_raw)
  );

  // A flush outranks any event or issue decided in the same cycle.
  always_comb begin
    evt_carry  = carry_raw && !clr;
    evt_borrow = borrow_raw && !clr;
    pend_pos   = !pending_q[PEND_W-1] && (pending_q != '0);
    pend_neg   = pending_q[PEND_W-1];
    iss_inc    = (state_q == ST_IDLE) && !clr && pend_pos;
    iss_dec    = (state_q == ST_IDLE) && !clr && pend_neg;
    add        = {1'b0, evt_carry} + {1'b0, iss_dec};
    sub        = {1'b0, evt_borrow} + {1'b0, iss_inc};
    sum        = {{2{pending_q[PEND_W-1]}}, pending_q} + SUM_W'(add) - SUM_W'(sub);
    pending_d  = clamp_pend(sum);
    sat_d      = (sum > PEND_MAX) || (sum < PEND_MIN);
    if (clr) begin
      pending_d = '0;
      sat_d     = 1'b0;
    end
  end

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (clr || carry_raw || borrow_raw) lock_cnt_d = '0;
    else if (enable && (lock_cnt_q != LOCK_TOP)) lock_cnt_d = lock_cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    inc_d   = inc_q;
    dec_d   = dec_q;
    case (state_q)
      ST_IDLE: begin
        if (iss_inc || iss_dec) begin
          state_d = ST_PULSE;
          tmr_d   = PULSE_LAST;
          inc_d   = iss_inc;
          dec_d   = iss_dec;
        end
      end
      ST_PULSE: begin
        if (tmr_q == '0) begin
          state_d = ST_GUARD;
          tmr_d   = GUARD_LAST;
          inc_d   = 1'b0;
          dec_d   = 1'b0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_GUARD: begin
        if (tmr_q == '0) state_d = ST_IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      sat_q      <= 1'b0;
      pending_q  <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      sat_q      <= sat_d;
      pending_q  <= pending_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign inc     = inc_q;
  assign dec     = dec_q;
  assign pending = pending_q;
  assign sat     = sat_q;
  assign locked  = (lock_cnt_q == LOCK_TOP);

endmodule
